// File: rtl/rv32i_types.sv
// Shared core types: CDB payload, arbitration mode and bus sizing constants.
package rv32i_types;

  localparam int unsigned TOTAL_FU = 6;
  localparam int unsigned NUM_CDB  = 2;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  // Completed-instruction payload carried from an FU to the regfile/scoreboard/RVFI.
  typedef struct packed {
    logic [63:0] order;
    logic [31:0] inst;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        trap;
  } cdb_entry_t;

  // An entry is squashed by a redirect when it is strictly younger than the branch.
  function automatic logic is_younger(input logic [63:0] order, input logic [63:0] flush_order);
    return order > flush_order;
  endfunction

endpackage

// File: rtl/cdb_grant_picker.sv
// Combinational picker: finds up to NUM_CDB requesters scanning from a start index with wrap.
module cdb_grant_picker #(
  parameter int unsigned NUM_FU  = 6,
  parameter int unsigned NUM_CDB = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_FU)
) (
  input  logic [NUM_FU-1:0]  req,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   port_idx [NUM_CDB],
  output logic [NUM_CDB-1:0] port_valid,
  output logic [NUM_FU-1:0]  grant
);

  int unsigned found;
  logic        in_pass;

  // Two passes (start..end, then 0..start-1) form the wrapped scan; k-th hit drives port k.
  always_comb begin
    port_valid = '0;
    grant      = '0;
    found      = 0;
    in_pass    = 1'b0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      port_idx[k] = '0;
    end
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        in_pass = (p == 0) ? (i >= 32'(start)) : (i < 32'(start));
        if (in_pass && req[i] && (found < NUM_CDB)) begin
          for (int unsigned k = 0; k < NUM_CDB; k++) begin
            if (found == k) begin
              port_idx[k]   = IDX_W'(i);
              port_valid[k] = 1'b1;
            end
          end
          grant[i] = 1'b1;
          found    = found + 1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_multi_arbiter.sv
// Multi-port CDB arbiter: per-FU holding slots, fixed/RR grant, registered broadcast, flush squash.
module cdb_multi_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned NUM_FU   = TOTAL_FU,
  parameter int unsigned NUM_CDB  = rv32i_types::NUM_CDB,
  parameter arb_mode_t   ARB_MODE = ARB_RR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_FU-1:0]  fu_valid,
  input  cdb_entry_t         fu_data [NUM_FU],
  output logic [NUM_FU-1:0]  fu_ready,
  input  logic               flush,
  input  logic [63:0]        flush_order,
  output logic [NUM_CDB-1:0] cdb_valid,
  output cdb_entry_t         cdb_data [NUM_CDB],
  output logic [31:0]        conflict_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0]  slot_valid;
  cdb_entry_t         slot_data [NUM_FU];
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   pick_start;

  logic [IDX_W-1:0]   port_idx [NUM_CDB];
  logic [NUM_CDB-1:0] port_valid;
  logic [NUM_FU-1:0]  grant;

  logic [NUM_FU-1:0]  take;
  logic [NUM_FU-1:0]  slot_young;
  logic [NUM_FU-1:0]  in_young;
  cdb_entry_t         port_entry [NUM_CDB];
  logic [NUM_CDB-1:0] port_young;
  logic [IDX_W-1:0]   rr_next;
  logic               any_grant;
  logic               conflict;

  // Fixed mode always scans from slot 0.
  assign pick_start = (ARB_MODE == ARB_RR) ? rr_ptr : '0;

  cdb_grant_picker #(
    .NUM_FU  (NUM_FU),
    .NUM_CDB (NUM_CDB)
  ) u_picker (
    .req        (slot_valid),
    .start      (pick_start),
    .port_idx   (port_idx),
    .port_valid (port_valid),
    .grant      (grant)
  );

  // A slot frees when empty or when it drains this cycle, allowing same-edge refill.
  assign fu_ready  = ~slot_valid | grant;
  assign take      = fu_valid & fu_ready;
  assign any_grant = |port_valid;
  assign conflict  = |(slot_valid & ~grant);

  // Flush filter for held and incoming entries.
  always_comb begin
    slot_young = '0;
    in_young   = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      slot_young[i] = flush && is_younger(slot_data[i].order, flush_order);
      in_young[i]   = flush && is_younger(fu_data[i].order, flush_order);
    end
  end

  // Route granted slot payloads to their ports and flag squashed ones.
  always_comb begin
    port_young = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      port_entry[k] = slot_data[port_idx[k]];
      port_young[k] = flush && is_younger(port_entry[k].order, flush_order);
    end
  end

  // Next round-robin pointer: one past the last slot granted (ports fill in scan order).
  always_comb begin
    rr_next = rr_ptr;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      if (port_valid[k]) begin
        rr_next = (port_idx[k] == IDX_W'(NUM_FU - 1)) ? '0 : port_idx[k] + IDX_W'(1);
      end
    end
  end

  // Holding slots: load on transfer (dropped if squashed), clear on grant or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        slot_data[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (take[i]) begin
          slot_valid[i] <= !in_young[i];
          slot_data[i]  <= fu_data[i];
        end else if (grant[i] || slot_young[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Broadcast registers; payload holds while the port is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid <= '0;
      for (int unsigned k = 0; k < NUM_CDB; k++) begin
        cdb_data[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_CDB; k++) begin
        cdb_valid[k] <= port_valid[k] && !port_young[k];
        if (port_valid[k]) begin
          cdb_data[k] <= port_entry[k];
        end
      end
    end
  end

  // Round-robin pointer and saturating lost-arbitration counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= '0;
      conflict_cnt <= '0;
    end else begin
      if (any_grant) begin
        rr_ptr <= rr_next;
      end
      if (conflict && (conflict_cnt != 32'hFFFF_FFFF)) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cdb_multi_arbiter.sv
// Directed bench for cdb_multi_arbiter: RR and fixed-priority instances, scoreboard of broadcasts.
module tb_cdb_multi_arbiter;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  fu_valid;
  logic [5:0]  fx_valid;
  cdb_entry_t  fu_data [6];
  logic        flush;
  logic [63:0] flush_order;

  logic [5:0]  rr_ready;
  logic [1:0]  rr_cdb_valid;
  cdb_entry_t  rr_cdb_data [2];
  logic [31:0] rr_cnt;

  logic [5:0]  fx_ready;
  logic [1:0]  fx_cdb_valid;
  cdb_entry_t  fx_cdb_data [2];
  logic [31:0] fx_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;

  typedef struct {
    bit          fx;
    int unsigned port;
    bit          valid;
    logic [63:0] order;
    int unsigned due;
  } sb_item_t;

  sb_item_t exp_q[$];

  always #5 clk = ~clk;

  cdb_multi_arbiter #(.NUM_FU(6), .NUM_CDB(2), .ARB_MODE(ARB_RR)) dut (
    .clk (clk), .rst (rst), .fu_valid (fu_valid), .fu_data (fu_data), .fu_ready (rr_ready),
    .flush (flush), .flush_order (flush_order), .cdb_valid (rr_cdb_valid),
    .cdb_data (rr_cdb_data), .conflict_cnt (rr_cnt)
  );

  cdb_multi_arbiter #(.NUM_FU(6), .NUM_CDB(2), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk (clk), .rst (rst), .fu_valid (fx_valid), .fu_data (fu_data), .fu_ready (fx_ready),
    .flush (flush), .flush_order (flush_order), .cdb_valid (fx_cdb_valid),
    .cdb_data (fx_cdb_data), .conflict_cnt (fx_cnt)
  );

  function automatic cdb_entry_t mk(input logic [63:0] ord);
    cdb_entry_t e;
    e          = '0;
    e.order    = ord;
    e.rd       = ord[4:0];
    e.data     = 32'(ord * 3);
    e.pc_rdata = 32'(ord * 4);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input bit fx, input int unsigned port, input bit valid,
                            input logic [63:0] order, input int unsigned due);
    sb_item_t it;
    it.fx = fx; it.port = port; it.valid = valid; it.order = order; it.due = due;
    exp_q.push_back(it);
  endtask

  // Pop and compare every scoreboard entry due at the current cycle.
  task automatic sb_check();
    sb_item_t   keep[$];
    logic       ov;
    cdb_entry_t oe;
    string      tag;
    foreach (exp_q[i]) begin
      if (exp_q[i].due == cyc) begin
        ov  = exp_q[i].fx ? fx_cdb_valid[exp_q[i].port] : rr_cdb_valid[exp_q[i].port];
        oe  = exp_q[i].fx ? fx_cdb_data[exp_q[i].port] : rr_cdb_data[exp_q[i].port];
        tag = $sformatf("sb_%s_c%0d_p%0d", exp_q[i].fx ? "fx" : "rr", cyc, exp_q[i].port);
        chk({tag, "_valid"}, 64'(ov), 64'(exp_q[i].valid));
        if (exp_q[i].valid) begin
          chk({tag, "_order"}, oe.order, exp_q[i].order);
          chk({tag, "_data"}, 64'(oe.data), 64'(mk(exp_q[i].order).data));
        end
      end else begin
        keep.push_back(exp_q[i]);
      end
    end
    exp_q = keep;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    sb_check();
  endtask

  int unsigned c0;
  int unsigned cnt_item [6];
  logic [5:0]  xfer;

  initial begin
    fu_valid    = '0;
    fx_valid    = '0;
    flush       = 1'b0;
    flush_order = '0;
    for (int i = 0; i < 6; i++) fu_data[i] = mk(64'(i));

    // Reset with every FU presenting a result.
    #1 rst = 1'b1;
    fu_valid = '1;
    fx_valid = '1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(rr_ready), 64'h3F);
    chk("rst_cdb_valid", 64'(rr_cdb_valid), 64'h0);
    chk("rst_cdb_data", rr_cdb_data[0].order, 64'h0);
    chk("rst_cnt", 64'(rr_cnt), 64'h0);
    chk("rst_fx_ready", 64'(fx_ready), 64'h3F);
    fu_valid = '0;
    fx_valid = '0;
    rst      = 1'b0;
    cyc      = 0;

    // Round-robin rotation with all six FUs streaming.
    c0 = cyc;
    for (int i = 0; i < 6; i++) begin
      cnt_item[i] = 0;
      fu_data[i]  = mk(64'(100 + 10 * i));
    end
    fu_valid = '1;
    expect_out(0, 0, 0, 0, c0 + 1);
    expect_out(0, 0, 1, 100, c0 + 2); expect_out(0, 1, 1, 110, c0 + 2);
    expect_out(0, 0, 1, 120, c0 + 3); expect_out(0, 1, 1, 130, c0 + 3);
    expect_out(0, 0, 1, 140, c0 + 4); expect_out(0, 1, 1, 150, c0 + 4);
    expect_out(0, 0, 1, 101, c0 + 5); expect_out(0, 1, 1, 111, c0 + 5);
    for (int s = 0; s < 5; s++) begin
      if (s == 1) chk("rr_ready_after_load", 64'(rr_ready), 64'h03);
      if (s == 2) chk("rr_conflict_first", 64'(rr_cnt), 64'h1);
      xfer = fu_valid & rr_ready;
      tick();
      for (int i = 0; i < 6; i++) begin
        if (xfer[i]) begin
          cnt_item[i]++;
          fu_data[i] = mk(64'(100 + 10 * i + int'(cnt_item[i])));
        end
      end
    end
    fu_valid = '0;

    // Asynchronous reset while slots are still occupied.
    rst = 1'b1;
    #1;
    chk("midrst_cdb_valid", 64'(rr_cdb_valid), 64'h0);
    chk("midrst_ready", 64'(rr_ready), 64'h3F);
    chk("midrst_cnt", 64'(rr_cnt), 64'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("midrst_no_replay0", 64'(rr_cdb_valid), 64'h0);
    tick();
    chk("midrst_no_replay1", 64'(rr_cdb_valid), 64'h0);

    // FU3 streams back-to-back for eight cycles.
    c0 = cyc;
    for (int k = 0; k < 8; k++) begin
      expect_out(0, 0, 1, 64'(200 + k), c0 + 2 + k);
    end
    expect_out(0, 1, 0, 0, c0 + 5);
    expect_out(0, 0, 0, 0, c0 + 10);
    fu_valid[3] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      fu_data[3] = mk(64'(200 + k));
      chk($sformatf("stream_ready_%0d", k), 64'(rr_ready[3]), 64'h1);
      tick();
    end
    fu_valid = '0;
    tick();
    tick();

    // Flush: 20 older, 30 younger granted, 25 older stalled, 35 younger stalled, 40 incoming.
    c0 = cyc;
    fu_data[0] = mk(20); fu_data[1] = mk(30); fu_data[2] = mk(25); fu_data[3] = mk(35);
    fu_valid   = 6'b001111;
    expect_out(0, 0, 1, 20, c0 + 2); expect_out(0, 1, 0, 0, c0 + 2);
    expect_out(0, 0, 1, 25, c0 + 3); expect_out(0, 1, 0, 0, c0 + 3);
    expect_out(0, 0, 0, 0, c0 + 4);  expect_out(0, 1, 0, 0, c0 + 4);
    tick();
    fu_valid    = 6'b010000;
    fu_data[4]  = mk(40);
    flush       = 1'b1;
    flush_order = 64'd25;
    chk("flush_ready_stall", 64'(rr_ready), 64'h33);
    tick();
    fu_valid = '0;
    flush    = 1'b0;
    chk("flush_ready_after", 64'(rr_ready), 64'h3F);
    tick();
    tick();

    // Fixed priority on the second instance: orders 10, 11, 12 on FUs 0, 1, 3.
    c0 = cyc;
    fu_data[0] = mk(10); fu_data[1] = mk(11); fu_data[3] = mk(12);
    fx_valid   = 6'b001011;
    expect_out(1, 0, 1, 10, c0 + 2); expect_out(1, 1, 1, 11, c0 + 2);
    expect_out(1, 0, 1, 12, c0 + 3); expect_out(1, 1, 0, 0, c0 + 3);
    tick();
    fx_valid = '0;
    chk("fx_ready_loser", 64'(fx_ready), 64'h37);
    tick();
    chk("fx_conflict_one", 64'(fx_cnt), 64'h1);
    tick();
    chk("fx_conflict_hold", 64'(fx_cnt), 64'h1);
    tick();

    // Counter saturation from a backdoor preload.
    force dut_fx.conflict_cnt = 32'hFFFF_FFFE;
    #1 release dut_fx.conflict_cnt;
    chk("sat_preload", 64'(fx_cnt), 64'hFFFF_FFFE);
    fx_valid = '1;
    tick();
    chk("sat_idle_before", 64'(fx_cnt), 64'hFFFF_FFFE);
    chk("sat_ready_starve", 64'(fx_ready), 64'h03);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk($sformatf("sat_cnt_%0d", s), 64'(fx_cnt), 64'hFFFF_FFFF);
    end
    fx_valid = '0;
    tick();

    chk("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
